// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO hazard stalls plus mult/div busy scoreboard.
// Optional stall statistics counters are enabled by defining PIPE_STALL_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 33,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_halt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_md,
    input  logic       id_hilo_acc,
    input  logic       id_branch_taken,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    output logic       pc_wena,
    output logic       ifid_wena,
    output logic       idex_wena,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       md_start,
    output logic       md_busy
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [31:0] stat_lu_stalls,
    output logic [31:0] stat_md_stalls
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, md_haz, stall;
    logic             rs_hit, rt_hit;

    assign rs_hit   = id_use_rs & (id_rs == ex_dest);
    assign rt_hit   = id_use_rt & (id_rt == ex_dest);
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_dest != 5'd0) & (rs_hit | rt_hit);
    assign md_busy  = (state_q == BUSY);
    assign md_haz   = id_valid & md_busy & (id_is_md | id_hilo_acc);
    assign stall    = load_use | md_haz;

    // Halt outranks stall; a stalled ID/EX still loads a bubble.
    always_comb begin
        pc_wena     = 1'b0;
        ifid_wena   = 1'b0;
        idex_wena   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        if (rst || ext_halt) begin
            pc_wena = 1'b0;
        end else if (stall) begin
            idex_wena   = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_wena    = 1'b1;
            ifid_wena  = 1'b1;
            idex_wena  = 1'b1;
            ifid_flush = id_branch_taken;
            md_start   = id_valid & id_is_md;
        end
    end

    // The countdown keeps running through ext_halt so the unit's latency is preserved.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (md_start) begin
                state_d = BUSY;
                cnt_d   = CNT_W'(MD_CYCLES - 1);
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic lu_inc, md_inc;

    assign lu_inc = load_use & ~ext_halt;
    assign md_inc = md_haz & ~ext_halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lu_stalls <= '0;
            stat_md_stalls <= '0;
        end else begin
            if (lu_inc && stat_lu_stalls != 32'hFFFF_FFFF) begin
                stat_lu_stalls <= stat_lu_stalls + 32'd1;
            end
            if (md_inc && stat_md_stalls != 32'hFFFF_FFFF) begin
                stat_md_stalls <= stat_md_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences and a
// randomized run against a busy-cycles-remaining reference model.
module tb_pipe_hazard_ctrl;

    localparam int MD = 33;

    logic       clk, rst, ext_halt, id_valid, id_use_rs, id_use_rt, id_is_md, id_hilo_acc;
    logic       id_branch_taken, ex_valid, ex_mem_read;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       pc_wena, ifid_wena, idex_wena, ifid_flush, idex_bubble, md_start, md_busy;
`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stat_lu_stalls, stat_md_stalls;
    int          exp_lu, exp_md;
`endif

    pipe_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ext_halt(ext_halt), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_md(id_is_md),
        .id_hilo_acc(id_hilo_acc), .id_branch_taken(id_branch_taken), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .pc_wena(pc_wena), .ifid_wena(ifid_wena),
        .idex_wena(idex_wena), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .md_start(md_start), .md_busy(md_busy)
`ifdef PIPE_STALL_STATS_EN
        , .stat_lu_stalls(stat_lu_stalls), .stat_md_stalls(stat_md_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rem      = 0;     // model: busy cycles still to go
    logic [6:0] got;      // {pc, ifid, idex, flush, bubble, start, busy}

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] model_out();
        logic lu, mh, busy;
        busy = (rem > 0);
        lu = id_valid && ex_valid && ex_mem_read && ex_dest != 0 &&
             ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
        mh = id_valid && busy && (id_is_md || id_hilo_acc);
        if (rst) return 7'b0;
        if (ext_halt) return {6'b0, busy};
        if (lu || mh) return {5'b00101, 1'b0, busy};
        return {3'b111, id_branch_taken, 1'b0, id_valid && id_is_md, busy};
    endfunction

    function automatic logic [6:0] dut_out();
        return {pc_wena, ifid_wena, idex_wena, ifid_flush, idex_bubble, md_start, md_busy};
    endfunction

    // Inputs are already driven; compare, then advance one clock and the model.
    task automatic step(input string name);
        logic [6:0] e;
        #2;
        if (rst) rem = 0;
        e   = model_out();
        got = dut_out();
        check(name, got, e);
`ifdef PIPE_STALL_STATS_EN
        if (!rst && !ext_halt && e[2] && !e[6]) begin
            logic lu;
            lu = id_valid && ex_valid && ex_mem_read && ex_dest != 0 &&
                 ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
            if (lu) exp_lu++;
            if (id_valid && rem > 0 && (id_is_md || id_hilo_acc)) exp_md++;
        end
        if (rst) begin exp_lu = 0; exp_md = 0; end
`endif
        @(posedge clk);
        if (rst) rem = 0;
        else if (rem > 0) rem--;
        else if (e[1]) rem = MD;
        #1;
    endtask

    task automatic idle_inputs();
        ext_halt = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_md = 0; id_hilo_acc = 0; id_branch_taken = 0; ex_valid = 0; ex_mem_read = 0;
        ex_dest = 0;
    endtask

    typedef struct {
        logic       halt, iv;
        logic [4:0] rs, rt;
        logic       urs, urt, md, hl, br, ev, mr;
        logic [4:0] dst;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[15];
    int   stalls, busy_cnt;
    logic prev_busy;

    initial begin
        //          halt iv rs rt urs urt md hl br ev mr dst exp
        vecs[0]  = '{0, 1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 5, 7'b1110000};
        vecs[1]  = '{0, 1, 8, 2, 1, 1, 0, 0, 0, 1, 1, 8, 7'b0010100};
        vecs[2]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 7'b1110000};
        vecs[3]  = '{0, 1, 3, 9, 1, 1, 0, 0, 0, 1, 1, 9, 7'b0010100};
        vecs[4]  = '{0, 1, 3, 9, 1, 0, 0, 0, 0, 1, 1, 9, 7'b1110000};
        vecs[5]  = '{0, 1, 8, 2, 1, 1, 0, 0, 0, 1, 0, 8, 7'b1110000};
        vecs[6]  = '{0, 1, 8, 2, 1, 1, 0, 0, 0, 0, 1, 8, 7'b1110000};
        vecs[7]  = '{0, 0, 8, 2, 1, 1, 0, 0, 0, 1, 1, 8, 7'b1110000};
        vecs[8]  = '{0, 1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0, 7'b1111000};
        vecs[9]  = '{0, 1, 8, 2, 1, 1, 0, 0, 1, 1, 1, 8, 7'b0010100};
        vecs[10] = '{1, 1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0, 7'b0000000};
        vecs[11] = '{1, 1, 8, 2, 1, 1, 0, 0, 0, 1, 1, 8, 7'b0000000};
        vecs[12] = '{0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1110000};
        vecs[13] = '{1, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 7'b0000000};
        vecs[14] = '{0, 1, 8, 2, 1, 0, 1, 0, 0, 1, 1, 8, 7'b0010100};
`ifdef PIPE_STALL_STATS_EN
        exp_lu = 0; exp_md = 0;
`endif

        idle_inputs();
        rst = 1;
        #12;
        check("reset_outputs", dut_out(), 7'b0);
        @(posedge clk); #1;
        rst = 0;

        foreach (vecs[i]) begin
            ext_halt = vecs[i].halt; id_valid = vecs[i].iv; id_rs = vecs[i].rs;
            id_rt = vecs[i].rt; id_use_rs = vecs[i].urs; id_use_rt = vecs[i].urt;
            id_is_md = vecs[i].md; id_hilo_acc = vecs[i].hl; id_branch_taken = vecs[i].br;
            ex_valid = vecs[i].ev; ex_mem_read = vecs[i].mr; ex_dest = vecs[i].dst;
            #2;
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
            @(posedge clk); #1;
        end

        // div then mflo: mflo stalls for the whole occupancy, advances when busy drops.
        idle_inputs(); step("pre_div");
        id_valid = 1; id_is_md = 1;
        step("div_issue");
        check("div_start_pulse", {6'b0, got[1]}, 7'd1);
        id_is_md = 0; id_hilo_acc = 1;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            step("mflo_wait");
            if (got[6]) break;
            stalls++;
        end
        check("mflo_stall_cycles", 7'(stalls), 7'(MD));
        check("mflo_adv_busy", {6'b0, got[0]}, 7'd0);

        // Independent traffic during busy, then a second mult issues as busy drops.
        idle_inputs(); id_valid = 1; id_is_md = 1;
        step("mult_issue");
        id_is_md = 0; stalls = 0;
        for (int i = 0; i < 5; i++) begin
            step("addu_flow");
            if (!got[6]) stalls++;
        end
        check("addu_no_stall", 7'(stalls), 7'd0);
        id_is_md = 1; prev_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev_busy = got[0];
            step("mult2_wait");
            if (got[6]) break;
        end
        check("mult2_issue", {got[1], got[0], prev_busy}, 7'b0000101);
        idle_inputs();
        for (int i = 0; i < MD + 2; i++) step("drain");

        // Taken branch under load-use: no flush while stalled, flush once it clears.
        id_valid = 1; id_rs = 8; id_use_rs = 1; id_branch_taken = 1;
        ex_valid = 1; ex_mem_read = 1; ex_dest = 8;
        step("br_lu_stall");
        check("br_lu_flush0", {5'b0, got[3], got[2]}, 7'b0000001);
        ex_valid = 0; ex_mem_read = 0;
        step("br_after");
        check("br_flush1", {5'b0, got[3], got[2]}, 7'b0000010);

        // Reset in the middle of busy.
        idle_inputs(); id_valid = 1; id_is_md = 1;
        step("mult_rst_issue");
        idle_inputs(); id_valid = 1;
        for (int i = 0; i < 10; i++) step("busy_run");
        rst = 1;
        #1;
        check("rst_mid_busy", dut_out(), 7'b0);
        step("rst_hold");
        rst = 0; id_hilo_acc = 1;
        step("mflo_after_rst");
        check("mflo_after_rst_ok", {got[6], got[0]}, 7'b10);
        idle_inputs();

        // ext_halt mid-busy must not stretch the busy window.
        id_valid = 1; id_is_md = 1;
        step("mult_halt_issue");
        id_valid = 0; id_is_md = 0; busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 3) begin ext_halt = 1; id_valid = 1; id_is_md = 1; end
            if (i == 8) begin ext_halt = 0; id_valid = 0; id_is_md = 0; end
            step("halt_busy");
            if (i >= 3 && i < 8) check("halt_enables", {got[6:4], got[1]}, 7'b0);
            if (!got[0]) break;
            busy_cnt++;
        end
        check("halt_busy_len", 7'(busy_cnt), 7'(MD));

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ext_halt = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_is_md = ($urandom_range(0, 5) == 0); id_hilo_acc = ($urandom_range(0, 4) == 0);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            ex_valid = 1'($urandom); ex_mem_read = 1'($urandom);
            ex_dest = 5'($urandom_range(0, 3));
            step("random");
        end
        rst = 0; idle_inputs();
        step("final");

`ifdef PIPE_STALL_STATS_EN
        n_checks++;
        if (stat_lu_stalls == 32'(exp_lu) && stat_md_stalls == 32'(exp_md)) n_pass++;
        else $display("FAIL stats: got %0d/%0d expected %0d/%0d", stat_lu_stalls,
                      stat_md_stalls, exp_lu, exp_md);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
